// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared word type, address constants and index helper
// Purpose: common types for the data RAM and its requesters.
//   word_t      : 32-bit data/address word
//   WORD_BYTES  : bytes per word
//   ADDR_SHIFT  : byte-address to word-index shift
package ram_pkg;

  typedef logic [31:0] word_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_SHIFT = 2;

  // Byte address to word index; the byte-lane bits are simply dropped.
  function automatic logic [31-ADDR_SHIFT:0] word_index(input word_t addr);
    return addr[31:ADDR_SHIFT];
  endfunction

endpackage

// File: rtl/ram_if.sv
// rtl/ram_if.sv - request/response interface between a requester and the data RAM
// Purpose: bundles one address, separate read/write strobes, store/load data
// and the ready handshake.
//   modport ram       : in addr/store/ren/wen, out load/ready
//   modport requester : mirror of ram
interface ram_if;
  import ram_pkg::*;

  word_t addr;
  word_t store;
  word_t load;
  logic  ren;
  logic  wen;
  logic  ready;

  modport ram (
    input  addr,
    input  store,
    input  ren,
    input  wen,
    output load,
    output ready
  );

  modport requester (
    output addr,
    output store,
    output ren,
    output wen,
    input  load,
    input  ready
  );

endinterface

// File: rtl/ram_array.sv
// rtl/ram_array.sv - RAM_SIZE x 32-bit storage, synchronous write, asynchronous read
// Purpose: the raw memory array behind the data RAM.
//   clk   : write clock
//   we    : write enable, commits wdata to mem[idx] on the rising edge
//   idx   : word index shared by the read and write port
//   wdata : write data
//   rdata : combinational read of mem[idx]
module ram_array
  import ram_pkg::*;
#(
  parameter int RAM_SIZE = 1024,
  localparam int IW = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  word_t         wdata,
  output word_t         rdata
);

  // No reset on the array: contents survive a core reset.
  word_t mem [RAM_SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ram.sv
// rtl/ram.sv - single-port word RAM with programmable access latency
// Purpose: data RAM for the core; LATENCY wait cycles are inserted before each
// request completes (0 = single-cycle).
//   clk  : system clock
//   nrst : asynchronous reset, active-high
//   rif  : ram_if.ram port (addr, store, ren, wen in; load, ready out)
module ram
  import ram_pkg::*;
#(
  parameter int RAM_SIZE = 1024,
  parameter int LATENCY  = 0
) (
  input  logic clk,
  input  logic nrst,
  ram_if.ram   rif
);

  localparam int IW = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);

  logic [CW-1:0] wcnt;
  logic          req;
  logic          done;
  logic          in_range;
  logic          we;
  logic [IW-1:0] idx;
  word_t         rdata;

  assign req  = rif.ren | rif.wen;
  assign done = req && (wcnt == LAT_C);

  // addr[31:2] < RAM_SIZE is the same test as addr < RAM_SIZE*4 on the byte
  // address; the 33-bit compare keeps large RAM_SIZE values from wrapping.
  assign in_range = {1'b0, rif.addr} < 33'(64'(RAM_SIZE) * 64'(WORD_BYTES));
  assign idx      = IW'(word_index(rif.addr));

  // A write never lands while reset is held, even if the counter says done.
  assign we = rif.wen && done && in_range && !nrst;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      wcnt <= '0;
    end else if (!req || done) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + CW'(1);
    end
  end

  ram_array #(
    .RAM_SIZE(RAM_SIZE)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .idx  (idx),
    .wdata(rif.store),
    .rdata(rdata)
  );

  assign rif.ready = !req || done;
  // Read data is the pre-edge contents, so a simultaneous write shows old data.
  assign rif.load  = (rif.ren && in_range) ? rdata : '0;

  a_strobes_known: assert property (
    @(posedge clk) disable iff (nrst) !$isunknown({rif.ren, rif.wen})
  );

  a_addr_stable: assert property (
    @(posedge clk) disable iff (nrst) (req && !rif.ready) |=> $stable(rif.addr)
  );

endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - scoreboard bench for ram at LATENCY 0, 3 and 4
module tb_ram;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic [2:0]       ren_d, wen_d, ready_o;
  logic [2:0][31:0] addr_d, store_d, load_o;

  ram_if bus0 ();
  ram_if bus1 ();
  ram_if bus2 ();

  assign bus0.addr = addr_d[0]; assign bus0.store = store_d[0];
  assign bus0.ren  = ren_d[0];  assign bus0.wen   = wen_d[0];
  assign bus1.addr = addr_d[1]; assign bus1.store = store_d[1];
  assign bus1.ren  = ren_d[1];  assign bus1.wen   = wen_d[1];
  assign bus2.addr = addr_d[2]; assign bus2.store = store_d[2];
  assign bus2.ren  = ren_d[2];  assign bus2.wen   = wen_d[2];
  assign load_o[0] = bus0.load; assign ready_o[0] = bus0.ready;
  assign load_o[1] = bus1.load; assign ready_o[1] = bus1.ready;
  assign load_o[2] = bus2.load; assign ready_o[2] = bus2.ready;

  ram #(.RAM_SIZE(1024), .LATENCY(0)) u0 (.clk(clk), .nrst(nrst), .rif(bus0));
  ram #(.RAM_SIZE(1024), .LATENCY(3)) u3 (.clk(clk), .nrst(nrst), .rif(bus1));
  ram #(.RAM_SIZE(1024), .LATENCY(4)) u4 (.clk(clk), .nrst(nrst), .rif(bus2));

  int n_cmp = 0;
  int n_bad = 0;

  word_t q0[$];
  word_t q1[$];
  word_t q2[$];

  task automatic check(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input int d, input word_t v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic word_t pop_exp(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Every completed read (ren with ready, sampled mid-cycle) is scored.
  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (ren_d[d] && ready_o[d]) begin
          if (q_size(d) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_load dut%0d: got %h, expected no read", d, load_o[d]);
          end else begin
            check($sformatf("load dut%0d", d), load_o[d], pop_exp(d));
          end
        end
      end
    end
  endtask

  // Called just after a rising edge; returns the count of mid-cycle samples
  // with ready low before ready was seen, then releases after the completion edge.
  task automatic access(input int d, input logic r, input logic w,
                        input word_t a, input word_t s, output int waits);
    ren_d[d]   = r;
    wen_d[d]   = w;
    addr_d[d]  = a;
    store_d[d] = s;
    waits      = 0;
    @(negedge clk);
    while (!ready_o[d] && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!ready_o[d]) begin
      check($sformatf("ready_timeout dut%0d", d), {31'd0, ready_o[d]}, 32'd1);
    end
    @(posedge clk);
    #1;
    ren_d[d] = 1'b0;
    wen_d[d] = 1'b0;
  endtask

  task automatic wr(input int d, input word_t a, input word_t s, output int waits);
    access(d, 1'b0, 1'b1, a, s, waits);
  endtask

  task automatic rd(input int d, input word_t a, input word_t exp, output int waits);
    push_exp(d, exp);
    access(d, 1'b1, 1'b0, a, 32'h0, waits);
  endtask

  initial begin
    int w;
    int bad_waits;

    nrst    = 1'b1;
    ren_d   = '0;
    wen_d   = '0;
    addr_d  = '0;
    store_d = '0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;

    for (int d = 0; d < 3; d++) begin
      check($sformatf("idle_ready dut%0d", d), {31'd0, ready_o[d]}, 32'd1);
      check($sformatf("idle_load dut%0d", d), load_o[d], 32'h0);
    end
    @(posedge clk);
    #1;

    // LATENCY 0: fill every word with its own byte address, then read back.
    bad_waits = 0;
    for (int i = 0; i < 1024; i++) begin
      wr(0, 32'(i * 4), 32'(i * 4), w);
      if (w != 0) bad_waits++;
    end
    check("lat0_write_waits", 32'(bad_waits), 32'd0);
    bad_waits = 0;
    for (int i = 0; i < 1024; i++) begin
      rd(0, 32'(i * 4), 32'(i * 4), w);
      if (w != 0) bad_waits++;
    end
    check("lat0_read_waits", 32'(bad_waits), 32'd0);

    // Out of range: write is dropped, read gives zero, word 0 untouched.
    wr(0, 32'd4096, 32'h12345678, w);
    check("oor_write_waits", 32'(w), 32'd0);
    rd(0, 32'd4096, 32'h0, w);
    rd(0, 32'h0, 32'h0, w);
    rd(0, 32'd4092, 32'd4092, w);

    // LATENCY 3: ready low for three edges, completes on the fourth.
    wr(1, 32'h10, 32'hDEADBEEF, w);
    check("lat3_write_waits", 32'(w), 32'd3);
    rd(1, 32'h10, 32'hDEADBEEF, w);
    check("lat3_read_waits", 32'(w), 32'd3);

    // Simultaneous read and write: load shows old data, later read shows new.
    wr(1, 32'h20, 32'hAAAA5555, w);
    push_exp(1, 32'hAAAA5555);
    access(1, 1'b1, 1'b1, 32'h20, 32'h5555AAAA, w);
    check("rw_waits", 32'(w), 32'd3);
    rd(1, 32'h20, 32'h5555AAAA, w);

    // Misaligned address lands in word 4.
    wr(1, 32'h13, 32'h0BADF00D, w);
    rd(1, 32'h10, 32'h0BADF00D, w);

    // LATENCY 4: reset mid-write aborts it and restarts the wait count.
    wr(2, 32'h8, 32'h11112222, w);
    check("lat4_write_waits", 32'(w), 32'd4);
    addr_d[2]  = 32'h8;
    store_d[2] = 32'hCAFEF00D;
    wen_d[2]   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    #1;
    check("ready_in_reset_with_wen", {31'd0, ready_o[2]}, 32'd0);
    @(posedge clk);
    #1;
    nrst     = 1'b0;
    wen_d[2] = 1'b0;
    rd(2, 32'h8, 32'h11112222, w);
    check("post_reset_read_waits", 32'(w), 32'd4);
    wr(2, 32'h8, 32'hCAFEF00D, w);
    check("reissued_write_waits", 32'(w), 32'd4);
    rd(2, 32'h8, 32'hCAFEF00D, w);

    repeat (3) @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("scoreboard_drained dut%0d", d), 32'(q_size(d)), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
